pipe_skid_stage: RTL and testbench
==================================

Name: pipe_skid_stage

Overview:
- Parametrised elastic pipeline register for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces the fixed-field, stall-vector stage register with a generic payload, a valid/ready handshake and a 2-entry skid buffer, so upstream `ready` is registered (no combinational ready path through the stage).
- Supports synchronous flush for branch/jump recovery, drives a configurable bubble value when empty, and exposes occupancy and a stall-cycle counter.

Parameters:
- DATA_W, 134, payload width (e.g. reg1+reg2+Imm+rd+rd_enable+aluop+alusel+pc).
- BUBBLE_VAL, {DATA_W{1'b0}}, value driven on dn_data when the stage is empty (encodes NOP/NOP_SEL, rd_enable=0).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all held and incoming beats this cycle.
- up_valid  in  1  upstream beat present.
- up_ready  out  1  stage can accept (registered).
- up_data  in  DATA_W  upstream payload.
- dn_valid  out  1  beat present on output.
- dn_ready  in  1  downstream accepts.
- dn_data  out  DATA_W  output payload; BUBBLE_VAL when dn_valid=0.
- occupancy  out  2  entries held (0..2).
- stall_cnt  out  CNT_W  cycles with dn_valid=1 and dn_ready=0; saturating.

Behaviour:
- Storage: main entry (drives dn_*) and skid entry. Encoded states: EMPTY (0 entries), ONE (main only), TWO (main+skid).
- Definitions: acc = up_valid & up_ready; pop = dn_valid & dn_ready.
- Reset (rst=1 at posedge): state EMPTY, dn_valid=0, dn_data=BUBBLE_VAL, skid data=BUBBLE_VAL, up_ready=1, occupancy=0, stall_cnt=0. rst has priority over every other input.
- Flush (rst=0, flush=1): next state EMPTY, both entries to BUBBLE_VAL, up_ready=1. A beat offered in the same cycle is dropped, even if acc=1. stall_cnt is not cleared.
- Transitions when rst=0, flush=0:
  - EMPTY: acc → ONE, main<=up_data.
  - ONE: acc&pop → ONE, main<=up_data. acc&!pop → TWO, skid<=up_data. !acc&pop → EMPTY. Otherwise hold.
  - TWO: up_ready=0, so acc is impossible. pop → ONE, main<=skid, skid<=BUBBLE_VAL. Otherwise hold.
- up_ready = (state != TWO), registered from next state.
- Latency: a beat accepted at edge N is on dn_data/dn_valid after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle while dn_ready=1.
- Ordering: strict FIFO. No beat is duplicated or lost except by flush.
- up_data is sampled only when acc=1; its value is ignored otherwise.
- dn_data holds stable while dn_valid=1 and dn_ready=0.
- occupancy = 0/1/2 for EMPTY/ONE/TWO.
- stall_cnt: increments by 1 on each posedge where dn_valid=1 and dn_ready=0 (pre-edge values). It saturates at all-ones and never wraps. Only rst clears it.
- Bench checkers: up_valid must stay asserted with stable up_data until acc. Violation is undefined upstream behaviour, not a stage error.

Test Plan:
- Reset then stream: rst 2 cycles, then up_valid=1 with data 1,2,3,4 and dn_ready=1 → dn_data 1,2,3,4 on consecutive cycles, each 1 cycle after accept; occupancy stays 1; up_ready stays 1.
- Backpressure fill: ONE holding 0xA, dn_ready=0, offer 0xB → state TWO, up_ready=0 next cycle, dn_data stays 0xA. Raise dn_ready → outputs 0xA then 0xB; up_ready=1 one cycle after the first pop.
- Flush mid-stream: state TWO holding 0x5 and 0x6, flush=1 with up_valid=1 and data 0x7 → next cycle dn_valid=0, dn_data=BUBBLE_VAL, occupancy=0, up_ready=1; 0x5, 0x6 and 0x7 never appear.
- Stall counter: hold dn_valid=1 and dn_ready=0 for 10 cycles → stall_cnt=10. With CNT_W=4, hold 20 cycles → stall_cnt=15 (saturated). Flush → stall_cnt unchanged.
- Reset mid-operation: state TWO, rst=1 for one cycle with flush=0 and up_valid=1 → all outputs at reset values (stall_cnt=0) and no beat captured.
- Random valid/ready: 1000 cycles with 50% up_valid and 50% dn_ready, no flush → output sequence equals input sequence and dn_data is stable under backpressure.

Source files
------------

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline register with a 2-entry skid buffer.
// up_ready is a flop, so there is no combinational ready path from dn_ready
// back to the upstream stage. The main entry drives dn_*; the skid entry
// catches the one beat that can arrive while the main entry is blocked.
// Both entries park at BUBBLE_VAL whenever they are empty, which lets
// dn_data come straight from the main flop.
module pipe_skid_stage #(
  parameter int                DATA_W     = 134,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
  parameter int                CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] main_q, main_nxt;
  logic [DATA_W-1:0] skid_q, skid_nxt;
  logic              up_ready_q;
  logic [CNT_W-1:0]  stall_q;
  logic              acc, pop;

  assign acc = up_valid & up_ready_q;
  assign pop = dn_valid & dn_ready;

  // State and payload registers; rst beats flush beats normal operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      main_q     <= BUBBLE_VAL;
      skid_q     <= BUBBLE_VAL;
      up_ready_q <= 1'b1;
    end else begin
      state      <= state_nxt;
      main_q     <= main_nxt;
      skid_q     <= skid_nxt;
      up_ready_q <= (state_nxt != TWO);
    end
  end

  // Next-state and entry moves. Flush drops held beats and any incoming one.
  always_comb begin
    state_nxt = state;
    main_nxt  = main_q;
    skid_nxt  = skid_q;
    if (flush) begin
      state_nxt = EMPTY;
      main_nxt  = BUBBLE_VAL;
      skid_nxt  = BUBBLE_VAL;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            state_nxt = ONE;
            main_nxt  = up_data;
          end
        end
        ONE: begin
          if (acc && pop) begin
            main_nxt = up_data;
          end else if (acc) begin
            state_nxt = TWO;
            skid_nxt  = up_data;
          end else if (pop) begin
            state_nxt = EMPTY;
            main_nxt  = BUBBLE_VAL;
          end
        end
        TWO: begin
          // up_ready is low here, so only a pop can move the state.
          if (pop) begin
            state_nxt = ONE;
            main_nxt  = skid_q;
            skid_nxt  = BUBBLE_VAL;
          end
        end
        default: begin
          state_nxt = EMPTY;
          main_nxt  = BUBBLE_VAL;
          skid_nxt  = BUBBLE_VAL;
        end
      endcase
    end
  end

  // Saturating count of cycles where a beat is held but not taken.
  always_ff @(posedge clk) begin
    if (rst)
      stall_q <= '0;
    else if (dn_valid && !dn_ready && (stall_q != {CNT_W{1'b1}}))
      stall_q <= stall_q + 1'b1;
  end

  assign up_ready  = up_ready_q;
  assign dn_valid  = (state != EMPTY);
  assign dn_data   = main_q;
  assign occupancy = state;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed + random bench for pipe_skid_stage. A queue-based reference model
// (at most two beats, popped by downstream, pushed when fewer than two held)
// predicts every output after every clock edge. A second instance with a
// 4-bit stall counter exercises saturation.
module tb_pipe_skid_stage;
  localparam int DW = 32;
  localparam logic [DW-1:0] BUB = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst, flush, up_valid, dn_ready;
  logic [DW-1:0] up_data;
  logic          up_ready, dn_valid, up_ready4, dn_valid4;
  logic [DW-1:0] dn_data, dn_data4;
  logic [1:0]    occupancy, occupancy4;
  logic [15:0]   stall_cnt;
  logic [3:0]    stall_cnt4;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  int            mcnt, mcnt4;
  bit            last_acc;

  pipe_skid_stage #(.DATA_W(DW), .BUBBLE_VAL(BUB), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .up_valid(up_valid), .up_ready(up_ready), .up_data(up_data),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_data(dn_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_skid_stage #(.DATA_W(DW), .BUBBLE_VAL(BUB), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .up_valid(up_valid), .up_ready(up_ready4), .up_data(up_data),
    .dn_valid(dn_valid4), .dn_ready(dn_ready), .dn_data(dn_data4),
    .occupancy(occupancy4), .stall_cnt(stall_cnt4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One clock: drive inputs, clock, advance model on pre-edge values, compare.
  task automatic cyc(input bit r, input bit f, input bit uv, input logic [DW-1:0] ud, input bit dr);
    int  n;
    bit  stall;
    rst = r; flush = f; up_valid = uv; up_data = ud; dn_ready = dr;
    @(posedge clk);
    n        = mq.size();
    stall    = (n > 0) && !dr;
    last_acc = 1'b0;
    if (r) begin
      mq.delete(); mcnt = 0; mcnt4 = 0;
    end else begin
      if (stall) begin
        if (mcnt  < 65535) mcnt++;
        if (mcnt4 < 15)    mcnt4++;
      end
      if (f) mq.delete();
      else begin
        last_acc = uv && (n < 2);
        if (n > 0 && dr) void'(mq.pop_front());
        if (last_acc) mq.push_back(ud);
      end
    end
    #1;
    chk("dn_valid",  {63'd0, dn_valid}, {63'd0, mq.size() > 0});
    chk("dn_data",   {32'd0, dn_data}, {32'd0, (mq.size() > 0) ? mq[0] : BUB});
    chk("up_ready",  {63'd0, up_ready}, {63'd0, mq.size() < 2});
    chk("occupancy", {62'd0, occupancy}, 64'(mq.size()));
    chk("stall_cnt", {48'd0, stall_cnt}, 64'(mcnt));
    chk("stall_cnt4",{60'd0, stall_cnt4}, 64'(mcnt4));
    chk("dn_data4",  {32'd0, dn_data4}, {32'd0, dn_data});
  endtask

  initial begin
    bit            pend;
    logic [DW-1:0] pdata;
    rst = 1'b1; flush = 1'b0; up_valid = 1'b0; up_data = '0; dn_ready = 1'b0;
    mcnt = 0; mcnt4 = 0;

    // Reset, then check reset values explicitly
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_dn_data", {32'd0, dn_data}, {32'd0, BUB});
    chk("rst_up_ready", {63'd0, up_ready}, 64'd1);

    // Stream 1..4 with dn_ready=1
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 0, 1, DW'(i), 1);
      chk("stream_data", {32'd0, dn_data}, 64'(i));
      chk("stream_occ", {62'd0, occupancy}, 64'd1);
    end
    cyc(0, 0, 0, 0, 1);

    // Backpressure fill: hold 0xA, offer 0xB with dn_ready=0
    cyc(0, 0, 1, 32'hA, 0);
    cyc(0, 0, 1, 32'hB, 0);
    chk("bp_up_ready", {63'd0, up_ready}, 64'd0);
    chk("bp_hold", {32'd0, dn_data}, 64'hA);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("bp_second", {32'd0, dn_data}, 64'hB);
    chk("bp_ready_back", {63'd0, up_ready}, 64'd1);
    cyc(0, 0, 0, 0, 1);

    // Flush in TWO with a beat offered
    cyc(0, 0, 1, 32'h5, 0);
    cyc(0, 0, 1, 32'h6, 0);
    cyc(0, 1, 1, 32'h7, 0);
    chk("flush_valid", {63'd0, dn_valid}, 64'd0);
    chk("flush_data", {32'd0, dn_data}, {32'd0, BUB});
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk("flush_no_7", {63'd0, dn_valid}, 64'd0);

    // Stall counter: 10 cycles, then saturation of the 4-bit copy
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h11, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);
    chk("stall10", {48'd0, stall_cnt}, 64'd10);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0);
    chk("stall20", {48'd0, stall_cnt}, 64'd20);
    chk("stall_sat4", {60'd0, stall_cnt4}, 64'd15);
    cyc(0, 1, 0, 0, 1);
    chk("stall_after_flush", {48'd0, stall_cnt}, 64'd20);

    // Reset mid-operation in TWO with a beat offered
    cyc(0, 0, 1, 32'h21, 0);
    cyc(0, 0, 1, 32'h22, 0);
    cyc(1, 0, 1, 32'h23, 0);
    chk("rst_mid_occ", {62'd0, occupancy}, 64'd0);
    chk("rst_mid_stall", {48'd0, stall_cnt}, 64'd0);
    chk("rst_mid_data", {32'd0, dn_data}, {32'd0, BUB});

    // Random valid/ready; an offered beat stays stable until accepted
    pend = 1'b0; pdata = '0;
    for (int i = 0; i < 1000; i++) begin
      if (!pend && $urandom_range(1)) begin
        pend = 1'b1; pdata = $urandom;
      end
      cyc(0, 0, pend, pend ? pdata : DW'($urandom), $urandom_range(1) == 1);
      if (last_acc) pend = 1'b0;
    end
    // Drain
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    chk("drain_empty", {62'd0, occupancy}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
